// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and the target-side state encoding.
package i2c_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX_LOAD,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;
endpackage

// File: rtl/i2c_line_filter.sv
// Pad input conditioning: synchroniser, stability filter and single-cycle edge flags.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;
  logic                   prev_reg;

  // Lines idle high, so everything resets to 1 to avoid a false edge at reset release.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_reg  <= '1;
      cnt_reg   <= '0;
      level_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad};
      prev_reg <= level_reg;
      if (sync_reg[SYNC_STAGES-1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
        level_reg <= sync_reg[SYNC_STAGES-1];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = level_reg & ~prev_reg;
  assign fall  = ~level_reg & prev_reg;
endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target endpoint: START/STOP detection, address match, byte receive/transmit
// with clock stretching while the host supplies transmit data.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  EN,
  input  logic [I2C_ADDR_W-1:0] OWN_ADDR,
  input  logic                  ACK_EN,
  input  logic                  SCL_i,
  output logic                  SCL_OE,
  input  logic                  SDA_i,
  output logic                  SDA_OE,
  output logic [I2C_BYTE_W-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  TX_REQ,
  input  logic                  TX_VALID,
  input  logic [I2C_BYTE_W-1:0] TX_DATA,
  output logic                  ADDR_HIT,
  output logic                  RW,
  output logic                  STOP_DET,
  output logic                  NACK_DET,
  output logic                  BUSY
);
  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .CLK(CLK), .RESETn(RESETn), .pad(SCL_i), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .CLK(CLK), .RESETn(RESETn), .pad(SDA_i), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e            state_reg, state_next;
  logic [I2C_BYTE_W-1:0] sr_reg, rx_data_reg;
  logic [3:0]            bitcnt_reg;
  logic                  sda_oe_reg, matched_reg, rw_reg;
  logic                  rx_valid_reg, addr_hit_reg, stop_det_reg, nack_det_reg;

  logic                  start_cond, stop_cond, last_bit, addr_match;
  logic [I2C_BYTE_W-1:0] shifted;

  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;
  assign shifted    = {sr_reg[I2C_BYTE_W-2:0], sda};
  assign last_bit   = (bitcnt_reg == 4'd7);
  assign addr_match = (sr_reg[I2C_ADDR_W-1:0] == OWN_ADDR) && (OWN_ADDR != '0);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!EN)             state_next = ST_IDLE;
    else if (start_cond) state_next = ST_ADDR;
    else if (stop_cond)  state_next = ST_IDLE;
    else begin
      case (state_reg)
        ST_ADDR:     if (scl_rise && last_bit) state_next = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (scl_fall && bitcnt_reg == 4'd1) state_next = rw_reg ? ST_TX_LOAD : ST_RX;
        ST_RX:       if (scl_rise && last_bit) state_next = ST_RX_ACK;
        // sda_oe_reg still holds this slot's ACK decision at the closing fall
        ST_RX_ACK:   if (scl_fall && bitcnt_reg == 4'd1) state_next = sda_oe_reg ? ST_RX : ST_WAIT_STOP;
        ST_TX_LOAD:  if (TX_VALID) state_next = ST_TX;
        ST_TX:       if (scl_fall && bitcnt_reg == 4'd8) state_next = ST_TX_ACK;
        ST_TX_ACK: begin
          if (scl_rise && sda)                           state_next = ST_WAIT_STOP;
          else if (scl_fall && bitcnt_reg == 4'd1)       state_next = ST_TX_LOAD;
        end
        ST_IDLE, ST_WAIT_STOP: state_next = state_reg;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sr_reg       <= '0;
      rx_data_reg  <= '0;
      bitcnt_reg   <= '0;
      sda_oe_reg   <= 1'b0;
      matched_reg  <= 1'b0;
      rw_reg       <= 1'b0;
      rx_valid_reg <= 1'b0;
      addr_hit_reg <= 1'b0;
      stop_det_reg <= 1'b0;
      nack_det_reg <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      addr_hit_reg <= 1'b0;
      stop_det_reg <= 1'b0;
      nack_det_reg <= 1'b0;
      if (!EN) begin
        sr_reg      <= '0;
        bitcnt_reg  <= '0;
        sda_oe_reg  <= 1'b0;
        matched_reg <= 1'b0;
      end else if (start_cond) begin
        bitcnt_reg  <= '0;
        sda_oe_reg  <= 1'b0;
        matched_reg <= 1'b0;
      end else if (stop_cond) begin
        bitcnt_reg   <= '0;
        sda_oe_reg   <= 1'b0;
        matched_reg  <= 1'b0;
        stop_det_reg <= matched_reg;
      end else begin
        case (state_reg)
          ST_ADDR: if (scl_rise) begin
            sr_reg     <= shifted;
            bitcnt_reg <= last_bit ? 4'd0 : bitcnt_reg + 4'd1;
            if (last_bit && addr_match) begin
              addr_hit_reg <= 1'b1;
              rw_reg       <= sda;
              matched_reg  <= 1'b1;
            end
          end
          ST_RX: if (scl_rise) begin
            sr_reg     <= shifted;
            bitcnt_reg <= last_bit ? 4'd0 : bitcnt_reg + 4'd1;
            if (last_bit) begin
              rx_data_reg  <= shifted;
              rx_valid_reg <= 1'b1;
            end
          end
          // bitcnt 0 = before the 9th rise, 1 = after it
          ST_ADDR_ACK, ST_RX_ACK: begin
            if (scl_rise) bitcnt_reg <= 4'd1;
            else if (scl_fall) begin
              if (bitcnt_reg == 4'd0) begin
                sda_oe_reg <= (state_reg == ST_ADDR_ACK) || ACK_EN;
              end else begin
                sda_oe_reg <= 1'b0;
                bitcnt_reg <= '0;
              end
            end
          end
          ST_TX_LOAD: if (TX_VALID) begin
            sr_reg     <= TX_DATA;
            sda_oe_reg <= ~TX_DATA[I2C_BYTE_W-1];
          end
          ST_TX: begin
            if (scl_rise) bitcnt_reg <= bitcnt_reg + 4'd1;
            else if (scl_fall) begin
              if (bitcnt_reg == 4'd8) begin
                sda_oe_reg <= 1'b0;
                bitcnt_reg <= '0;
              end else begin
                sr_reg     <= {sr_reg[I2C_BYTE_W-2:0], sr_reg[I2C_BYTE_W-1]};
                sda_oe_reg <= ~sr_reg[I2C_BYTE_W-2];
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise) begin
              if (sda) nack_det_reg <= 1'b1;
              else     bitcnt_reg   <= 4'd1;
            end else if (scl_fall) begin
              bitcnt_reg <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    SCL_OE = EN && (state_reg == ST_TX_LOAD);
    TX_REQ = EN && (state_reg == ST_TX_LOAD);
    SDA_OE = EN && sda_oe_reg;
    BUSY   = (state_reg != ST_IDLE);
  end

  assign RX_DATA  = rx_data_reg;
  assign RX_VALID = rx_valid_reg;
  assign ADDR_HIT = addr_hit_reg;
  assign RW       = rw_reg;
  assign STOP_DET = stop_det_reg;
  assign NACK_DET = nack_det_reg;
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench: a master bus model drives open-drain SCL/SDA against the target at OWN_ADDR=0x2A.
module tb_i2c_slave_ctrl;
  localparam int Q = 50;  // SCL period = 4*Q CLK

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       EN = 1'b1;
  logic [6:0] OWN_ADDR = 7'h2A;
  logic       ACK_EN = 1'b1;
  logic       TX_VALID = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       SCL_OE, SDA_OE, RX_VALID, TX_REQ, ADDR_HIT, RW, STOP_DET, NACK_DET, BUSY;
  logic [7:0] RX_DATA;

  logic m_scl = 1'b1, m_sda = 1'b1, glitch = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = m_scl & ~SCL_OE;
  assign sda_line = m_sda & ~SDA_OE;

  i2c_slave_ctrl dut (
    .CLK(CLK), .RESETn(RESETn), .EN(EN), .OWN_ADDR(OWN_ADDR), .ACK_EN(ACK_EN),
    .SCL_i(scl_line), .SCL_OE(SCL_OE), .SDA_i(sda_line), .SDA_OE(SDA_OE),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .TX_REQ(TX_REQ), .TX_VALID(TX_VALID),
    .TX_DATA(TX_DATA), .ADDR_HIT(ADDR_HIT), .RW(RW), .STOP_DET(STOP_DET),
    .NACK_DET(NACK_DET), .BUSY(BUSY)
  );

  always #10 CLK = ~CLK;

  int hit_cnt = 0, rxv_cnt = 0, stop_cnt = 0, nack_cnt = 0, xfer_cnt = 0;
  int oe_run = 0, last_run = 0, max_run = 0;
  always @(posedge CLK) begin
    if (ADDR_HIT) hit_cnt <= hit_cnt + 1;
    if (RX_VALID) rxv_cnt <= rxv_cnt + 1;
    if (STOP_DET) stop_cnt <= stop_cnt + 1;
    if (NACK_DET) nack_cnt <= nack_cnt + 1;
    if (TX_REQ && TX_VALID) xfer_cnt <= xfer_cnt + 1;
    if (SCL_OE) oe_run <= oe_run + 1;
    else begin
      if (oe_run > 0) last_run <= oe_run;
      if (oe_run > max_run) max_run <= oe_run;
      oe_run <= 0;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic scl_release();
    int n = 0;
    m_scl = 1'b1;
    #1;
    while (!scl_line && n < 5000) begin
      cyc(1);
      n++;
    end
    if (!scl_line) chk("scl_release_tmo", 32'(scl_line), 1);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_sda = b;
    cyc(Q);
    scl_release();
    cyc(Q / 2);
    if (glitch && b) begin
      m_sda = 1'b0;
      cyc(1);
      m_sda = 1'b1;
    end
    cyc(Q / 2);
    r = sda_line;
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic byte_xfer(input logic [7:0] d, input logic ack_in,
                           output logic [7:0] rd, output logic ack_out);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(d[i], r);
      rd[i] = r;
    end
    bit_xfer(ack_in, ack_out);
    $display("byte wr=%02h rd=%02h ack_in=%0b ack_seen=%0b", d, rd, ack_in, ack_out);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    cyc(Q);
    scl_release();
    cyc(Q);
    m_sda = 1'b0;
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    cyc(Q);
    scl_release();
    cyc(Q);
    m_sda = 1'b1;
    cyc(Q);
  endtask

  task automatic serve(input int dly, input logic [7:0] d);
    int n = 0;
    while (!TX_REQ && n < 20000) begin
      cyc(1);
      n++;
    end
    if (!TX_REQ) chk("tx_req_tmo", 32'(TX_REQ), 1);
    cyc(dly);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    n = 0;
    while (TX_REQ && n < 100) begin
      cyc(1);
      n++;
    end
    TX_VALID = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       ak, r;
    int         h0, x0, s0, n0, t0;

    // Reset state
    cyc(5);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_oe", {30'd0, SCL_OE, SDA_OE}, 0);
    chk("rst_pulses", {28'd0, RX_VALID, ADDR_HIT, STOP_DET, NACK_DET}, 0);
    chk("rst_req_rw", {30'd0, TX_REQ, RW}, 0);
    chk("rst_rxdata", 32'(RX_DATA), 0);
    RESETn = 1'b1;
    cyc(10);

    // Write 0x54 A5 3C, STOP
    h0 = hit_cnt; x0 = rxv_cnt; s0 = stop_cnt;
    i2c_start();
    byte_xfer(8'h54, 1'b1, rd, ak);
    chk("w_addr_ack", 32'(ak), 0);
    chk("w_hit", 32'(hit_cnt - h0), 1);
    chk("w_rw", 32'(RW), 0);
    byte_xfer(8'hA5, 1'b1, rd, ak);
    chk("w_ack1", 32'(ak), 0);
    chk("w_rx1", 32'(RX_DATA), 32'h A5);
    byte_xfer(8'h3C, 1'b1, rd, ak);
    chk("w_ack2", 32'(ak), 0);
    chk("w_rx2", 32'(RX_DATA), 32'h3C);
    chk("w_rxv", 32'(rxv_cnt - x0), 2);
    i2c_stop();
    cyc(20);
    chk("w_stop_det", 32'(stop_cnt - s0), 1);
    chk("w_idle", 32'(BUSY), 0);

    // Foreign address 0x56
    h0 = hit_cnt; s0 = stop_cnt;
    i2c_start();
    byte_xfer(8'h56, 1'b1, rd, ak);
    chk("na_nack", 32'(ak), 1);
    chk("na_hit", 32'(hit_cnt - h0), 0);
    chk("na_busy", 32'(BUSY), 1);
    i2c_stop();
    cyc(20);
    chk("na_idle", 32'(BUSY), 0);
    chk("na_stop_det", 32'(stop_cnt - s0), 0);

    // OWN_ADDR 0 never matches
    OWN_ADDR = 7'h00;
    i2c_start();
    byte_xfer(8'h00, 1'b1, rd, ak);
    chk("a0_nack", 32'(ak), 1);
    i2c_stop();
    OWN_ADDR = 7'h2A;
    cyc(20);

    // Read 0x55: delayed C3 then preloaded 7E, master NACKs the second byte
    n0 = nack_cnt; s0 = stop_cnt; t0 = xfer_cnt;
    fork
      begin
        serve(200, 8'hC3);
        cyc(1);
        TX_DATA  = 8'h7E;
        TX_VALID = 1'b1;
      end
      begin
        i2c_start();
        byte_xfer(8'h55, 1'b1, rd, ak);
        chk("r_addr_ack", 32'(ak), 0);
        byte_xfer(8'hFF, 1'b0, rd, ak);
        chk("r_data1", 32'(rd), 32'hC3);
      end
    join
    chk("r_long_stretch", 32'(max_run >= 195 && max_run <= 210), 1);
    byte_xfer(8'hFF, 1'b1, rd, ak);
    TX_VALID = 1'b0;
    chk("r_data2", 32'(rd), 32'h7E);
    chk("r_short_stretch", 32'(last_run >= 1 && last_run <= 2), 1);
    chk("r_xfers", 32'(xfer_cnt - t0), 2);
    chk("r_nack_det", 32'(nack_cnt - n0), 1);
    chk("r_released", {30'd0, SCL_OE, SDA_OE}, 0);
    chk("r_wait_busy", 32'(BUSY), 1);
    i2c_stop();
    cyc(20);
    chk("r_stop_det", 32'(stop_cnt - s0), 1);
    chk("r_idle", 32'(BUSY), 0);

    // Write 0x54 11, repeated START, read 0x55
    h0 = hit_cnt;
    i2c_start();
    byte_xfer(8'h54, 1'b1, rd, ak);
    byte_xfer(8'h11, 1'b1, rd, ak);
    chk("rs_ack", 32'(ak), 0);
    i2c_start();
    byte_xfer(8'h55, 1'b1, rd, ak);
    chk("rs_addr_ack", 32'(ak), 0);
    chk("rs_rx", 32'(RX_DATA), 32'h11);
    chk("rs_hits", 32'(hit_cnt - h0), 2);
    chk("rs_rw", 32'(RW), 1);
    chk("rs_tx_req", 32'(TX_REQ), 1);
    chk("rs_stretch", 32'(SCL_OE), 1);
    TX_DATA  = 8'h81;
    TX_VALID = 1'b1;
    cyc(2);
    TX_VALID = 1'b0;
    byte_xfer(8'hFF, 1'b1, rd, ak);
    chk("rs_data", 32'(rd), 32'h81);
    i2c_stop();
    cyc(20);

    // ACK_EN=0: address ACKed, data NACKed but still delivered
    ACK_EN = 1'b0;
    x0 = rxv_cnt;
    i2c_start();
    byte_xfer(8'h54, 1'b1, rd, ak);
    chk("ne_addr_ack", 32'(ak), 0);
    byte_xfer(8'h5A, 1'b1, rd, ak);
    chk("ne_data_nack", 32'(ak), 1);
    chk("ne_rxv", 32'(rxv_cnt - x0), 1);
    chk("ne_rx", 32'(RX_DATA), 32'h5A);
    chk("ne_wait_busy", 32'(BUSY), 1);
    i2c_stop();
    ACK_EN = 1'b1;
    cyc(20);

    // 1-CLK SDA glitches while SCL high: idle and mid-transfer
    m_sda = 1'b0;
    cyc(1);
    m_sda = 1'b1;
    cyc(20);
    chk("gl_idle", 32'(BUSY), 0);
    s0 = stop_cnt;
    glitch = 1'b1;
    i2c_start();
    byte_xfer(8'h54, 1'b1, rd, ak);
    byte_xfer(8'hFF, 1'b1, rd, ak);
    glitch = 1'b0;
    chk("gl_ack", 32'(ak), 0);
    chk("gl_rx", 32'(RX_DATA), 32'hFF);
    i2c_stop();
    cyc(20);
    chk("gl_stop_det", 32'(stop_cnt - s0), 1);

    // RESETn low mid-read while driving SDA
    s0 = stop_cnt;
    TX_DATA  = 8'h00;
    TX_VALID = 1'b1;
    i2c_start();
    byte_xfer(8'h55, 1'b1, rd, ak);
    bit_xfer(1'b1, r);
    TX_VALID = 1'b0;
    chk("rr_bit", 32'(r), 0);
    chk("rr_sda_drv", 32'(SDA_OE), 1);
    #3 RESETn = 1'b0;
    #1;
    chk("rr_released", {30'd0, SCL_OE, SDA_OE}, 0);
    chk("rr_idle", 32'(BUSY), 0);
    cyc(2);
    RESETn = 1'b1;
    i2c_stop();
    cyc(20);
    chk("rr_stop_det", 32'(stop_cnt - s0), 0);

    // EN low mid-read while driving SDA
    TX_DATA  = 8'h00;
    TX_VALID = 1'b1;
    i2c_start();
    byte_xfer(8'h55, 1'b1, rd, ak);
    bit_xfer(1'b1, r);
    TX_VALID = 1'b0;
    chk("en_sda_drv", 32'(SDA_OE), 1);
    EN = 1'b0;
    cyc(1);
    chk("en_released", {30'd0, SCL_OE, SDA_OE}, 0);
    chk("en_tx_req", 32'(TX_REQ), 0);
    chk("en_idle", 32'(BUSY), 0);
    EN = 1'b1;
    i2c_stop();
    cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
